root_digit_collector: RTL and testbench

- Downstream stage of the digit-serial square-root core.
- Consumes the core's per-cycle result digit stream, MSB first. Digits are in {0,1,2}, and the weight of digit i is 2^-i.
- Converts the redundant digit stream into a conventional unsigned binary result word.
- Presents the word with a valid/ack handshake to the consuming logic.

---
 rtl/root_digit_collector.sv | 93 +++++++++
 tb/tb_root_digit_collector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/root_digit_collector.sv
// Collects the MSB-first {0,1,2} root digit stream into a binary word with a done/ack handshake.
// Optional guard-digit rounding is enabled by defining ROOT_COLLECT_ROUND_EN.
module root_digit_collector #(
   parameter int N_DIGITS = 8,
   parameter int W_CNT    = 4
) (
   input  logic                i_clk,
   input  logic                i_Reset,
   input  logic                i_start,
   input  logic                i_digit_valid,
   input  logic [1:0]          i_digit,
   input  logic                i_ack,
   output logic [N_DIGITS:0]   o_result,
   output logic                o_done,
   output logic                o_busy,
   output logic [W_CNT-1:0]    o_count,
   output logic                o_error
);

`ifdef ROOT_COLLECT_ROUND_EN
   localparam int LEN = N_DIGITS + 1;
`else
   localparam int LEN = N_DIGITS;
`endif
   localparam logic [W_CNT-1:0] LAST = W_CNT'(LEN - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
   state_t state, state_nxt;

   logic                take, last, stray, acc_en;
   logic [1:0]          dval;
   logic [N_DIGITS:0]   acc, acc_nxt, fin;

   // start always wins: a digit on a start cycle is dropped in every state
   assign take    = (state == COLLECT) && i_digit_valid && !i_start;
   assign last    = take && (o_count == LAST);
   assign stray   = (state != COLLECT) && i_digit_valid && !i_start;
   assign dval    = (i_digit == 2'b11) ? 2'd2 : i_digit;
   assign acc_nxt = {acc[N_DIGITS-1:0], 1'b0} + (N_DIGITS+1)'(dval);

`ifdef ROOT_COLLECT_ROUND_EN
   // the guard digit only rounds; it never shifts into acc
   assign acc_en = take && (o_count != LAST);
   assign fin    = acc + {{N_DIGITS{1'b0}}, |i_digit};
`else
   assign acc_en = take;
   assign fin    = acc_nxt;
`endif

   always_ff @(posedge i_clk or negedge i_Reset) begin
      if (!i_Reset) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = COLLECT;
         COLLECT: if (i_start) state_nxt = COLLECT;
                  else if (last) state_nxt = DONE;
         DONE:    if (i_start) state_nxt = COLLECT;
                  else if (i_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state == COLLECT);
      o_done = (state == DONE);
   end

   always_ff @(posedge i_clk or negedge i_Reset) begin
      if (!i_Reset) begin
         acc      <= '0;
         o_result <= '0;
         o_count  <= '0;
         o_error  <= 1'b0;
      end else if (i_start) begin
         acc      <= '0;
         o_count  <= '0;
         o_error  <= 1'b0;
      end else begin
         if (take) begin
            o_count <= o_count + W_CNT'(1);
            if (i_digit == 2'b11) o_error <= 1'b1;
         end
         if (acc_en) acc      <= acc_nxt;
         if (last)   o_result <= fin;
         if (stray)  o_error  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_root_digit_collector.sv
// Bench for root_digit_collector: vector table, hand corner sequences and randomized streams vs an arithmetic model.
module tb_root_digit_collector;
   localparam int N = 4;
   localparam int W = 4;
`ifdef ROOT_COLLECT_ROUND_EN
   localparam int LEN = N + 1;
   localparam bit RND = 1'b1;
`else
   localparam int LEN = N;
   localparam bit RND = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_Reset, i_start, i_digit_valid, i_ack;
   logic [1:0]    i_digit;
   logic [N:0]    o_result;
   logic          o_done, o_busy, o_error;
   logic [W-1:0]  o_count;

   root_digit_collector #(.N_DIGITS(N), .W_CNT(W)) dut (
      .i_clk(i_clk), .i_Reset(i_Reset), .i_start(i_start), .i_digit_valid(i_digit_valid),
      .i_digit(i_digit), .i_ack(i_ack), .o_result(o_result), .o_done(o_done),
      .o_busy(o_busy), .o_count(o_count), .o_error(o_error)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int d [5];
      int gap;
      int res;
      int res_rnd;
      int err;
   } vec_t;

   vec_t tbl [5];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // digit i carries weight 2^(N-1-i) in the integer result; guard rounds half up
   function automatic int model(input int d [5]);
      int v = 0;
      for (int i = 0; i < N; i++) v += ((d[i] == 3) ? 2 : d[i]) * (1 << (N - 1 - i));
      if (RND && d[N] != 0) v++;
      return v;
   endfunction

   function automatic int model_err(input int d [5]);
      for (int i = 0; i < LEN; i++) if (d[i] == 3) return 1;
      return 0;
   endfunction

   task automatic pulse_start();
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic feed(input int d [5], input int gap);
      for (int i = 0; i < LEN; i++) begin
         i_digit_valid = 1'b1;
         i_digit       = d[i][1:0];
         step();
         i_digit_valid = 1'b0;
         if (i < LEN - 1)
            for (int g = 0; g < gap; g++) begin
               step();
               chk("gap_busy", o_busy, 1);
            end
      end
   endtask

   task automatic run(input int d [5], input int gap, input int res, input int err);
      pulse_start();
      chk("start_busy", o_busy, 1);
      chk("start_count", o_count, 0);
      chk("start_err", o_error, 0);
      feed(d, gap);
      chk("done_lat", o_done, 1);
      chk("result", o_result, res);
      chk("count", o_count, LEN);
      chk("err", o_error, err);
   endtask

   task automatic add(input int i, input int d0, input int d1, input int d2, input int d3,
                      input int d4, input int gap, input int res, input int rr, input int err);
      tbl[i].d       = '{d0, d1, d2, d3, d4};
      tbl[i].gap     = gap;
      tbl[i].res     = res;
      tbl[i].res_rnd = rr;
      tbl[i].err     = err;
   endtask

   initial begin
      int d [5];
      int exp;
      add(0, 1, 0, 1, 2, 1, 0, 12, 13, 0);
      add(1, 2, 2, 2, 2, 2, 2, 30, 31, 0);
      add(2, 1, 3, 0, 0, 0, 0, 16, 16, 1);
      add(3, 0, 0, 0, 1, 2, 1,  1,  2, 0);
      add(4, 1, 0, 1, 2, 0, 0, 12, 12, 0);

      i_Reset = 1'b0; i_start = 1'b0; i_digit_valid = 1'b0; i_digit = 2'd0; i_ack = 1'b0;
      #12;
      chk("rst_result", o_result, 0);
      chk("rst_done", o_done, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_count", o_count, 0);
      chk("rst_err", o_error, 0);
      i_Reset = 1'b1;
      step();

      foreach (tbl[k]) begin
         exp = RND ? tbl[k].res_rnd : tbl[k].res;
         run(tbl[k].d, tbl[k].gap, exp, tbl[k].err);
         repeat (3) step();
         chk("done_hold", o_done, 1);
         chk("result_hold", o_result, exp);
         i_ack = 1'b1;
         step();
         i_ack = 1'b0;
         chk("ack_done", o_done, 0);
         chk("ack_busy", o_busy, 0);
         chk("ack_result", o_result, exp);
      end

      // restart mid-collection; digit on the start cycle is dropped; stray ack ignored
      pulse_start();
      d = '{2, 2, 0, 0, 0};
      i_digit_valid = 1'b1; i_digit = 2'd2; step();
      step();
      i_start = 1'b1; i_digit = 2'd2; step();
      i_start = 1'b0; i_digit_valid = 1'b0;
      chk("restart_count", o_count, 0);
      chk("restart_busy", o_busy, 1);
      i_ack = 1'b1; step(); i_ack = 1'b0;
      chk("ack_collect", o_busy, 1);
      d = '{0, 0, 0, 1, 0};
      feed(d, 0);
      chk("restart_result", o_result, 1);
      chk("restart_done", o_done, 1);

      // digit while DONE: error, result untouched
      i_digit_valid = 1'b1; i_digit = 2'd1; step(); i_digit_valid = 1'b0;
      chk("done_digit_err", o_error, 1);
      chk("done_digit_res", o_result, 1);
      chk("done_digit_done", o_done, 1);

      // start with ack in DONE goes straight to COLLECT
      i_start = 1'b1; i_ack = 1'b1; step(); i_start = 1'b0; i_ack = 1'b0;
      chk("sa_busy", o_busy, 1);
      chk("sa_done", o_done, 0);
      chk("sa_err", o_error, 0);
      chk("sa_count", o_count, 0);
      d = '{2, 2, 2, 2, 2};
      feed(d, 0);
      chk("max_result", o_result, RND ? 31 : 30);
      i_ack = 1'b1; step(); i_ack = 1'b0;

      // stray digit in IDLE
      i_digit_valid = 1'b1; i_digit = 2'd1; step(); i_digit_valid = 1'b0;
      chk("idle_digit_err", o_error, 1);
      chk("idle_digit_busy", o_busy, 0);

      // asynchronous reset mid-collection
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         i_digit_valid = 1'b1; i_digit = 2'd1; step();
      end
      i_digit_valid = 1'b0;
      #3 i_Reset = 1'b0;
      #1;
      chk("arst_result", o_result, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_count", o_count, 0);
      chk("arst_done", o_done, 0);
      chk("arst_err", o_error, 0);
      #2 i_Reset = 1'b1;
      step();
      i_digit_valid = 1'b1; i_digit = 2'd2; step(); i_digit_valid = 1'b0;
      chk("post_rst_err", o_error, 1);
      chk("post_rst_done", o_done, 0);

      // randomized streams vs arithmetic model
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < 5; i++)
            d[i] = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         run(d, int'($urandom_range(0, 2)), model(d), model_err(d));
         if ($urandom_range(0, 1) == 1) begin
            i_ack = 1'b1; step(); i_ack = 1'b0;
            chk("rnd_ack", o_done, 0);
         end
      end
      i_ack = 1'b1; step(); i_ack = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
